// File: rtl/pio_pulse_seq_pkg.sv
// rtl/pio_pulse_seq_pkg.sv - shared types and field positions for the PIO pulse sequencer
//
// Purpose: opcode and FSM state enums plus bit positions of the command word
// (pio_cmd) and status word (pio_status).
// Ports: none (package).
package pio_pulse_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_SET_DELAY  = 3'd1,
    OP_SET_WIDTH  = 3'd2,
    OP_SET_PERIOD = 3'd3,
    OP_SET_COUNT  = 3'd4,
    OP_ARM        = 3'd5,
    OP_FIRE       = 3'd6,
    OP_ABORT      = 3'd7
  } opcode_e;

  // Encodings are visible to software through pio_status[4:3].
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_PULSE = 2'd3
  } state_e;

  localparam int CMD_TOG    = 15;
  localparam int CMD_OP_HI  = 14;
  localparam int CMD_OP_LO  = 12;
  localparam int CMD_ARG_HI = 11;

  localparam int STS_ACK    = 7;
  localparam int STS_BUSY   = 6;
  localparam int STS_ERR    = 5;
  localparam int STS_ST_HI  = 4;
  localparam int STS_ST_LO  = 3;
  localparam int STS_OP_HI  = 2;

endpackage

// File: rtl/pio_pulse_seq_if.sv
// rtl/pio_pulse_seq_if.sv - HPS PIO command/status bus bundle
//
// Purpose: groups the pio_0 command export and the pio_1 status export.
// Signals: pio_cmd[15:0] (HPS -> fabric), pio_status[7:0] (fabric -> HPS).
// Modports: master (HPS side), slave (sequencer side).
interface pio_pulse_seq_if;
  logic [15:0] pio_cmd;
  logic [7:0]  pio_status;

  modport master (output pio_cmd, input pio_status);
  modport slave  (input pio_cmd, output pio_status);
endinterface

// File: rtl/pio_tick_div.sv
// rtl/pio_tick_div.sv - timing tick prescaler with synchronous clear
//
// Purpose: emits o_tick once every PRESCALE clocks; i_clr restarts the count
// so the first tick after a clear lands exactly PRESCALE clocks later.
// Ports: clk, rst (async, active-high), i_clr (sync restart), o_tick (strobe).
module pio_tick_div #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DW-1:0] LAST = DW'(PRESCALE - 1);

  logic [DW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/pio_pulse_seq.sv
// rtl/pio_pulse_seq.sv - command-driven delayed/counted pulse-train sequencer
//
// Purpose: decodes toggle-handshaked commands from the HPS PIO, holds the
// delay/width/period/count configuration and generates the pulse train.
// Ports: clk_clk, reset_reset (async, active-high), pio (slave modport:
// pio_cmd in, pio_status out), trig_in (rising-edge start), pulse_out,
// seq_done (one-cycle strobe at the end of a finite train).
// Build option: PIO_PULSE_SEQ_TRIG_SYNC_EN adds a 2-flop synchronizer on trig_in.
module pio_pulse_seq
  import pio_pulse_seq_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int PRESCALE = 1
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  pio_pulse_seq_if.slave  pio,
  input  logic            trig_in,
  output logic            pulse_out,
  output logic            seq_done
);
  logic [15:0]      r_cmd_q;
  logic             r_ack_q, r_err, r_high, r_seq_done, r_trig_d;
  logic [2:0]       r_last_op;
  logic [CNT_W-1:0] r_delay, r_width, r_period, r_count, r_remain, r_ticks;
  state_e           r_state;

  state_e           w_state_nxt;
  logic             w_high_nxt, w_restart, w_done, w_tick, w_term, w_busy;
  logic             w_exec, w_abort, w_fire, w_arm, w_cfg_err, w_last;
  logic             w_trig_src, w_trig_rise;
  opcode_e          w_op;
  logic [CNT_W-1:0] w_arg, w_d_len, w_w_len, w_l_len, w_len;
  logic [CNT_W:0]   w_diff;

  // A command executes once per toggle flip of the registered command word.
  assign w_exec    = (r_cmd_q[CMD_TOG] != r_ack_q);
  assign w_op      = opcode_e'(r_cmd_q[CMD_OP_HI:CMD_OP_LO]);
  assign w_arg     = r_cmd_q[CNT_W-1:0];
  assign w_busy    = (r_state != ST_IDLE);
  assign w_abort   = w_exec && (w_op == OP_ABORT);
  assign w_cfg_err = w_exec && w_busy && (w_op != OP_NOP) && (w_op != OP_ABORT);
  assign w_fire    = w_exec && !w_busy && (w_op == OP_FIRE);
  assign w_arm     = w_exec && !w_busy && (w_op == OP_ARM);

`ifdef PIO_PULSE_SEQ_TRIG_SYNC_EN
  logic [1:0] r_trig_sync;
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) r_trig_sync <= '0;
    else             r_trig_sync <= {r_trig_sync[0], trig_in};
  end
  assign w_trig_src = r_trig_sync[1];
`else
  assign w_trig_src = trig_in;
`endif
  assign w_trig_rise = w_trig_src & ~r_trig_d;

  // Phase lengths in ticks; zero settings behave as one tick.
  assign w_d_len = (r_delay == '0) ? CNT_W'(1) : r_delay;
  assign w_w_len = (r_width == '0) ? CNT_W'(1) : r_width;
  assign w_diff  = {1'b0, r_period} - {1'b0, w_w_len};
  assign w_l_len = (w_diff[CNT_W] || (w_diff == '0)) ? CNT_W'(1) : w_diff[CNT_W-1:0];

  always_comb begin
    w_len = CNT_W'(1);
    if (r_state == ST_DELAY)     w_len = w_d_len;
    else if (r_state == ST_PULSE) w_len = r_high ? w_w_len : w_l_len;
  end

  assign w_term = w_tick && (r_ticks == (w_len - CNT_W'(1)));
  // remain was already decremented at the end of the preceding high phase.
  assign w_last = (r_count != '0) && (r_remain == '0);

  pio_tick_div #(.PRESCALE(PRESCALE)) u_div (
    .clk    (clk_clk),
    .rst    (reset_reset),
    .i_clr  (w_restart),
    .o_tick (w_tick)
  );

  // State register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state <= ST_IDLE;
      r_high  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_high  <= w_high_nxt;
    end
  end

  // Next-state logic; ABORT overrides triggers and phase ends.
  always_comb begin
    w_state_nxt = r_state;
    w_high_nxt  = r_high;
    w_restart   = 1'b0;
    w_done      = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_high_nxt  = 1'b0;
      w_restart   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            w_state_nxt = ST_DELAY;
            w_restart   = 1'b1;
          end else if (w_arm) begin
            w_state_nxt = ST_ARMED;
            w_restart   = 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_trig_rise) begin
            w_state_nxt = ST_DELAY;
            w_restart   = 1'b1;
          end
        end
        ST_DELAY: begin
          if (w_term) begin
            w_state_nxt = ST_PULSE;
            w_high_nxt  = 1'b1;
            w_restart   = 1'b1;
          end
        end
        ST_PULSE: begin
          if (w_term) begin
            w_restart = 1'b1;
            if (r_high) begin
              w_high_nxt = 1'b0;
            end else if (w_last) begin
              w_state_nxt = ST_IDLE;
              w_done      = 1'b1;
            end else begin
              w_high_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state so reset clears them at once.
  always_comb begin
    pulse_out      = (r_state == ST_PULSE) && r_high;
    seq_done       = r_seq_done;
    pio.pio_status = {r_ack_q, w_busy, r_err, r_state, r_last_op};
  end

  // Command capture, configuration and counters
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_cmd_q    <= '0;
      r_ack_q    <= 1'b0;
      r_err      <= 1'b0;
      r_last_op  <= '0;
      r_delay    <= '0;
      r_width    <= CNT_W'(1);
      r_period   <= CNT_W'(2);
      r_count    <= CNT_W'(1);
      r_remain   <= '0;
      r_ticks    <= '0;
      r_seq_done <= 1'b0;
      r_trig_d   <= 1'b0;
    end else begin
      r_cmd_q    <= pio.pio_cmd;
      r_trig_d   <= w_trig_src;
      r_seq_done <= w_done;

      if (w_restart)   r_ticks <= '0;
      else if (w_tick) r_ticks <= r_ticks + CNT_W'(1);

      if (!w_abort && w_term && (r_state == ST_DELAY))
        r_remain <= r_count;
      else if (!w_abort && w_term && (r_state == ST_PULSE) && r_high && (r_count != '0))
        r_remain <= r_remain - CNT_W'(1);

      if (w_exec) begin
        r_ack_q   <= r_cmd_q[CMD_TOG];
        r_last_op <= w_op;
        r_err     <= w_cfg_err;
        if (!w_busy) begin
          case (w_op)
            OP_SET_DELAY:  r_delay  <= w_arg;
            OP_SET_WIDTH:  r_width  <= w_arg;
            OP_SET_PERIOD: r_period <= w_arg;
            OP_SET_COUNT:  r_count  <= w_arg;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/pio_pulse_seq.md
Name: pio_pulse_seq

Overview:
- Command-driven pulse-train sequencer behind the HPS PIO pair.
- The HPS writes 16-bit command words through the pio_0 export and reads 8-bit status through the pio_1 export.
- The block decodes toggle-handshaked commands, holds timing configuration, and generates a delayed, counted pulse train on pulse_out.
- Generation starts immediately (FIRE) or on an external trigger (ARM).
- Sits in the FPGA fabric next to soc_system, on clk_clk.

Parameters:
- CNT_W, 12: width of the delay/width/period/count registers; equals the command operand width.
- PRESCALE, 1: clock cycles per timing tick (1..4096). All timing values are in ticks.

Ports:
- clk_clk  input  1  system clock; the PIO exports are synchronous to it.
- reset_reset  input  1  asynchronous, active-high reset.
- pio_cmd  input  16  from pio_0 export. Fields: [15] toggle, [14:12] opcode, [11:0] operand.
- pio_status  output  8  to pio_1 export. Fields: [7] ack toggle, [6] busy, [5] error, [4:3] state code, [2:0] last opcode.
- trig_in  input  1  external start trigger; rising-edge sensitive.
- pulse_out  output  1  generated pulse train.
- seq_done  output  1  one-cycle strobe when a finite train completes.

Behaviour:
- Reset: all outputs 0. delay=0, width=1, period=2, count=1. ack_q=0, cmd_q=0. FSM=IDLE.
- Command capture:
  - cmd_q registers pio_cmd every cycle.
  - A command executes on the edge where cmd_q[15] != ack_q; on that edge ack_q <= cmd_q[15].
  - pio_status[7] therefore follows a toggle change exactly 2 clocks later.
  - Exactly one execution per toggle. Operand/opcode changes without a toggle change are ignored.
- Opcodes:
  - 0 NOP.
  - 1 SET_DELAY, 2 SET_WIDTH, 3 SET_PERIOD, 4 SET_COUNT.
  - 5 ARM.
  - 6 FIRE.
  - 7 ABORT.
- Execution rules:
  - SET_* or ARM/FIRE while busy (FSM != IDLE): ignored, error<=1.
  - error clears on the next accepted command that does not itself error.
  - ABORT is always accepted. From any state: FSM=IDLE, pulse_out=0 on the following edge, no seq_done.
  - pio_status[2:0] = opcode of the last accepted command, including errored ones.
- FSM states and codes:
  - IDLE (0): FIRE -> DELAY; ARM -> ARMED.
  - ARMED (1): trig_in rising edge -> DELAY. Trigger edges in any other state are ignored.
  - DELAY (2): wait D = max(delay,1) ticks. The first pulse_out rise is D*PRESCALE clocks after the FIRE execute edge (or after the trigger edge is detected).
  - PULSE (3): alternates high phase and low phase.
    - High phase: W = max(width,1) ticks, pulse_out=1.
    - Low phase: L = max(period-W,1) ticks, pulse_out=0.
- busy = (FSM != IDLE).
- Count handling:
  - The count register is copied to a remaining counter at the DELAY->PULSE transition.
  - The counter decrements at the end of each high phase.
  - Reaching 0 after a high phase: the low phase still runs; at its end FSM=IDLE and seq_done pulses for 1 cycle.
  - count=0 means continuous until ABORT.
- Tick prescaler: free-running divider reset to 0 on every state entry, so timing is exact relative to entry.
- Widths: counters are CNT_W bits. period-W is computed in CNT_W+1 bits, saturated to a minimum of 1.
- Simultaneous events: ABORT wins over a trigger edge and over phase completion in the same cycle.
- Reset mid-train: pulse_out drops asynchronously. Config returns to reset values.

Optional Feature:
- Macro: PIO_PULSE_SEQ_TRIG_SYNC_EN.
- Defined: trig_in passes a 2-flop synchronizer before edge detection. Trigger-to-DELAY latency is 3 clocks.
- Undefined: trig_in is assumed synchronous to clk_clk; only the edge-detect register remains. Latency is 1 clock.
- Timing is measured from DELAY entry either way.

Decomposition:
- Package pio_pulse_seq_pkg holds:
  - opcode enum (OP_NOP..OP_ABORT);
  - state enum (ST_IDLE..ST_PULSE) with explicit 2-bit codes matching pio_status[4:3];
  - field index constants for the command and status words.
- One sub-module, pio_tick_div: PRESCALE divider with a sync clear and a tick strobe output.
- The main FSM and command decode stay in the top module.

Test Plan:
- Reset, then read status -> pio_status=8'h00, pulse_out=0. Toggle NOP -> status[7]=1 exactly 2 clocks after the pio_cmd change, status[2:0]=0.
- PRESCALE=1; SET_DELAY 5, SET_WIDTH 3, SET_PERIOD 8, SET_COUNT 2, FIRE -> pulse_out rises 5 clocks after FIRE executes; high 3 / low 5 / high 3 / low 5; then seq_done pulses once and busy=0.
- count=0, FIRE, ABORT after 40 clocks -> pulse_out=0 one clock after ABORT executes; FSM=IDLE; no seq_done.
- ARM; pulse trig_in high at clock 20 (macro defined) -> DELAY entered 3 clocks after the trig_in rise. A second trig_in pulse mid-train has no effect.
- SET_WIDTH while busy -> error=1, width unchanged on the next FIRE. Next accepted NOP -> error=0.
- Assert reset_reset during a high phase -> pulse_out=0 immediately. After release, FIRE uses delay=0→1 tick, width=1, period=2.
